board_controller: RTL and testbench
===================================

Name: board_controller

Overview:
- Owns the nine-cell tic-tac-toe board registers and drives pos1..pos9 into the win detector.
- Accepts player moves over a valid/ready handshake, checks legality, writes the current player's mark and alternates turns.
- Waits for the registered win detector to settle, then samples its winner code and locks the board when the game ends.

Parameters:
- SETTLE_CYCLES, 2, cycles spent in SETTLE after a write before winner is sampled; covers the detector's one-register latency plus margin; legal range 2..7.
- FIRST_PLAYER, 2'b01, mark of the player who moves first after reset or new_game; must be 2'b01 or 2'b10.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-low reset
- new_game  input  1  single-cycle request: clear board, start a new game
- move_valid  input  1  move request present
- move_pos  input  4  target cell, 1..9 row-major (1 = top-left, 9 = bottom-right)
- move_ready  output  1  high while in READY
- move_ack  output  1  one-cycle pulse: move accepted
- move_err  output  1  one-cycle pulse: move rejected
- winner  input  2  win detector code: 00 continue, 01 P1, 10 P2, 11 tie
- pos1..pos9  output  2 each  cell contents: 00 empty, 01 P1, 10 P2
- turn  output  2  player to move (01/10)
- move_count  output  4  number of marks on the board, 0..9
- game_over  output  1  high in DONE
- result  output  2  latched final winner code; 00 until the game ends

Behaviour:
- All outputs are registered.
- Reset (reset==0 at an edge) has top priority:
  - pos1..pos9 = 00, turn = FIRST_PLAYER, move_count = 0, result = 00.
  - game_over, move_ack, move_err = 0; move_ready = 1; state = READY.
- Reset asserted mid-SETTLE or in DONE aborts immediately with the same values.
- States: READY, SETTLE, DONE.
- READY, with move_valid == 1 at an edge:
  - Legal move (move_pos in 1..9 and that cell == 00):
    - Write turn into the cell, move_count += 1, toggle turn (01<->10).
    - Pulse move_ack, load settle counter with SETTLE_CYCLES, go to SETTLE.
    - move_ready = 0 in the same cycle the cell and move_ack update.
  - Illegal move (move_pos == 0, move_pos > 9, or cell occupied):
    - Pulse move_err; no board, turn or count change; stay in READY.
- SETTLE:
  - move_ready = 0. move_valid is ignored (no ack, no err).
  - Counter decrements each cycle. winner is sampled only on the edge where the counter reaches 1.
  - winner != 00 -> result = winner, game_over = 1, go to DONE.
  - winner == 00 and move_count == 9 -> defensive: result = 11, go to DONE.
  - Otherwise return to READY with move_ready = 1.
- DONE:
  - Board frozen. move_valid pulses move_err each cycle it is high. Remains here until new_game or reset.
- new_game == 1 in any state:
  - Same clearing as reset, except it does not require reset.
  - Takes priority over a coincident move_valid: that move gets no ack and no err.
- winner is ignored outside the sampling edge, so a stale code left in the detector after new_game is harmless.
- move_ack and move_err are never high together. Each lasts exactly one cycle per accepted or rejected request.
- move_count never wraps. A 10th write is impossible because a full board always exits SETTLE to DONE.

Decomposition:
- Shared package tictactoe_pkg holds:
  - Cell/player codes: CELL_EMPTY = 2'b00, CELL_P1 = 2'b01, CELL_P2 = 2'b10.
  - Result codes: RES_NONE = 2'b00, RES_P1 = 2'b01, RES_P2 = 2'b10, RES_TIE = 2'b11.
  - State encoding for READY/SETTLE/DONE.
  - Constant NUM_CELLS = 9.
- The win detector imports the same codes.
- No sub-module. The board write-decode is a 9-way index compare kept inline.

Test Plan:
- Reset, then move_valid with move_pos = 5 -> move_ack pulse; pos5 = 01, turn = 10, move_count = 1; move_ready low for 2 cycles, then high.
- Next move_pos = 5 by P2 -> move_err pulse; pos5 stays 01, turn stays 10, move_count stays 1. Then move_pos = 0 and move_pos = 10 -> move_err each, no state change.
- Moves 1,4,2,7,3 (P1 takes the top row), with the detector in the loop -> after the 5th move settles: game_over = 1, result = 01; a further move_valid -> move_err, board unchanged.
- Moves 1,2,3,5,4,6,8,7,9 -> move_count = 9, game_over = 1, result = 11. With a forced-00 winner stub, the same sequence -> result = 11 via the defensive path.
- new_game coincident with move_valid, in both SETTLE and DONE -> board all 00, turn = 01, move_count = 0, result = 00, state READY; no ack and no err.
- reset driven low for one edge mid-SETTLE after a move -> all outputs at reset values on the next cycle; next move_pos = 9 is accepted normally.

Source files
------------

// File: rtl/tictactoe_pkg.sv
// Shared tic-tac-toe codes: cell/player marks, result codes, controller states.
// No logic; imported by the board controller and the win detector.
// Encodings here must stay in step with the detector's winner output.
package tictactoe_pkg;

   localparam int NUM_CELLS = 9;

   typedef logic [1:0] cell_t;

   localparam cell_t CELL_EMPTY = 2'b00;
   localparam cell_t CELL_P1    = 2'b01;
   localparam cell_t CELL_P2    = 2'b10;

   localparam logic [1:0] RES_NONE = 2'b00;
   localparam logic [1:0] RES_P1   = 2'b01;
   localparam logic [1:0] RES_P2   = 2'b10;
   localparam logic [1:0] RES_TIE  = 2'b11;

   typedef enum logic [1:0] {
      ST_READY  = 2'b00,
      ST_SETTLE = 2'b01,
      ST_DONE   = 2'b10
   } state_t;

   // Mark of the player who moves after p.
   function automatic cell_t other_player(input cell_t p);
      return (p == CELL_P1) ? CELL_P2 : CELL_P1;
   endfunction

endpackage

// File: rtl/board_controller_if.sv
// Move request channel between a player source and the board controller.
// Ack/err are single-cycle responses; no data beyond the target cell.
// Source holds move_valid/move_pos until it sees ack or err.
interface board_controller_if;
   logic       move_valid;
   logic [3:0] move_pos;
   logic       move_ready;
   logic       move_ack;
   logic       move_err;

   modport master (
      output move_valid,
      output move_pos,
      input  move_ready,
      input  move_ack,
      input  move_err
   );

   modport slave (
      input  move_valid,
      input  move_pos,
      output move_ready,
      output move_ack,
      output move_err
   );
endinterface

// File: rtl/board_controller.sv
// Tic-tac-toe board owner: validates moves, writes marks, alternates turns, latches the result.
// Latency: ack/err one edge after the request; winner sampled SETTLE_CYCLES edges after a write.
// Backpressure: move_ready low during SETTLE (requests ignored); DONE rejects every request.
module board_controller
   import tictactoe_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter logic [1:0]  FIRST_PLAYER  = CELL_P1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                new_game,
   board_controller_if.slave   mv,
   input  logic [1:0]          winner,
   output logic [1:0]          pos1,
   output logic [1:0]          pos2,
   output logic [1:0]          pos3,
   output logic [1:0]          pos4,
   output logic [1:0]          pos5,
   output logic [1:0]          pos6,
   output logic [1:0]          pos7,
   output logic [1:0]          pos8,
   output logic [1:0]          pos9,
   output logic [1:0]          turn,
   output logic [3:0]          move_count,
   output logic                game_over,
   output logic [1:0]          result
);

   localparam logic [2:0] SETTLE_LOAD = 3'(SETTLE_CYCLES);

   state_t                        state;
   cell_t [NUM_CELLS-1:0]         board;
   cell_t                         turn_q;
   logic [3:0]                    count_q;
   logic [1:0]                    result_q;
   logic                          game_over_q;
   logic                          ready_q;
   logic                          ack_q;
   logic                          err_q;
   logic [2:0]                    settle_cnt;

   logic [NUM_CELLS-1:0]          cell_hit;
   logic [NUM_CELLS-1:0]          cell_free;
   logic                          move_legal;

   // Decode the requested cell: one-hot hit on 1..9, out-of-range positions hit nothing.
   always_comb begin
      cell_hit  = '0;
      cell_free = '0;
      for (int i = 0; i < NUM_CELLS; i++) begin
         cell_hit[i]  = (mv.move_pos == 4'(i + 1));
         cell_free[i] = (board[i] == CELL_EMPTY);
      end
      move_legal = |(cell_hit & cell_free);
   end

   // Game FSM: reset and new_game clear everything and win over any coincident move.
   always_ff @(posedge clk) begin
      if (!reset || new_game) begin
         state       <= ST_READY;
         board       <= '0;
         turn_q      <= FIRST_PLAYER;
         count_q     <= '0;
         result_q    <= RES_NONE;
         game_over_q <= 1'b0;
         ready_q     <= 1'b1;
         ack_q       <= 1'b0;
         err_q       <= 1'b0;
         settle_cnt  <= '0;
      end else begin
         ack_q <= 1'b0;
         err_q <= 1'b0;
         unique case (state)
            ST_READY: begin
               if (mv.move_valid) begin
                  if (move_legal) begin
                     for (int i = 0; i < NUM_CELLS; i++) begin
                        if (cell_hit[i]) begin
                           board[i] <= turn_q;
                        end
                     end
                     count_q    <= count_q + 4'd1;
                     turn_q     <= other_player(turn_q);
                     ack_q      <= 1'b1;
                     ready_q    <= 1'b0;
                     settle_cnt <= SETTLE_LOAD;
                     state      <= ST_SETTLE;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            ST_SETTLE: begin
               // The detector is registered; only trust winner once the count has run down.
               if (settle_cnt == 3'd1) begin
                  if (winner != RES_NONE) begin
                     result_q    <= winner;
                     game_over_q <= 1'b1;
                     state       <= ST_DONE;
                  end else if (count_q == 4'(NUM_CELLS)) begin
                     // Full board with no verdict: call it a tie so a tenth write can never happen.
                     result_q    <= RES_TIE;
                     game_over_q <= 1'b1;
                     state       <= ST_DONE;
                  end else begin
                     ready_q <= 1'b1;
                     state   <= ST_READY;
                  end
               end else begin
                  settle_cnt <= settle_cnt - 3'd1;
               end
            end
            ST_DONE: begin
               err_q <= mv.move_valid;
            end
            default: begin
               state <= ST_READY;
            end
         endcase
      end
   end

   assign mv.move_ready = ready_q;
   assign mv.move_ack   = ack_q;
   assign mv.move_err   = err_q;

   assign pos1       = board[0];
   assign pos2       = board[1];
   assign pos3       = board[2];
   assign pos4       = board[3];
   assign pos5       = board[4];
   assign pos6       = board[5];
   assign pos7       = board[6];
   assign pos8       = board[7];
   assign pos9       = board[8];
   assign turn       = turn_q;
   assign move_count = count_q;
   assign game_over  = game_over_q;
   assign result     = result_q;

endmodule

// File: tb/tb_board_controller.sv
// Bench for board_controller with a behavioural win detector in the loop.
// Detector has one register of latency, like the real one.
// Expected values come from a game-level model of the rules.
module tb_board_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic       new_game;
   logic [1:0] winner;
   logic       force_zero;
   logic [1:0] pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9;
   logic [1:0] turn;
   logic [3:0] move_count;
   logic       game_over;
   logic [1:0] result;

   board_controller_if mv_if ();

   board_controller dut (
      .clk        (clk),
      .reset      (reset),
      .new_game   (new_game),
      .mv         (mv_if),
      .winner     (winner),
      .pos1       (pos1),
      .pos2       (pos2),
      .pos3       (pos3),
      .pos4       (pos4),
      .pos5       (pos5),
      .pos6       (pos6),
      .pos7       (pos7),
      .pos8       (pos8),
      .pos9       (pos9),
      .turn       (turn),
      .move_count (move_count),
      .game_over  (game_over),
      .result     (result)
   );

   always #5 clk = ~clk;

   logic [17:0] dut_board;
   assign dut_board = {pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9};

   int checks = 0;
   int passed = 0;

   // ---------------- game rules ----------------
   int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                        '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

   function automatic logic [1:0] cell_of(input logic [17:0] b, input int i);
      return b[17 - 2*i -: 2];
   endfunction

   // Verdict of a board: line owner, else tie when full, else continue.
   function automatic logic [1:0] verdict(input logic [17:0] b);
      int filled = 0;
      for (int l = 0; l < 8; l++) begin
         logic [1:0] a;
         a = cell_of(b, lines[l][0]);
         if (a != 2'b00 && a == cell_of(b, lines[l][1]) && a == cell_of(b, lines[l][2]))
            return a;
      end
      for (int i = 0; i < 9; i++) if (cell_of(b, i) != 2'b00) filled++;
      return (filled == 9) ? 2'b11 : 2'b00;
   endfunction

   // Win detector stand-in (one register of latency).
   always_ff @(posedge clk) winner <= force_zero ? 2'b00 : verdict(dut_board);

   // ---------------- reference model ----------------
   logic [1:0] mb [9];
   logic [1:0] mturn;
   int         mcount;
   bit         mover;
   logic [1:0] mres;

   function automatic void model_clear();
      for (int i = 0; i < 9; i++) mb[i] = 2'b00;
      mturn = 2'b01; mcount = 0; mover = 0; mres = 2'b00;
   endfunction

   function automatic logic [17:0] model_board();
      logic [17:0] b = '0;
      for (int i = 0; i < 9; i++) b = {b[15:0], mb[i]};
      return b;
   endfunction

   // Apply one request to the model; returns 1 when it should be accepted.
   function automatic bit model_move(input int p);
      logic [1:0] v;
      if (mover || p < 1 || p > 9) return 0;
      if (mb[p-1] != 2'b00) return 0;
      mb[p-1] = mturn;
      mturn = (mturn == 2'b01) ? 2'b10 : 2'b01;
      mcount++;
      v = force_zero ? 2'b00 : verdict(model_board());
      if (v != 2'b00) begin mover = 1; mres = v; end
      else if (mcount == 9) begin mover = 1; mres = 2'b11; end
      return 1;
   endfunction

   // ---------------- drivers ----------------
   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic send_move(input int p, output bit ack, output bit err);
      mv_if.move_valid = 1'b1;
      mv_if.move_pos   = 4'(p);
      tick();
      ack = mv_if.move_ack;
      err = mv_if.move_err;
      mv_if.move_valid = 1'b0;
      mv_if.move_pos   = 4'd0;
   endtask

   task automatic settle();
      repeat (2) tick();
   endtask

   task automatic start_game();
      new_game = 1'b1; tick(); new_game = 1'b0;
      model_clear();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b0; repeat (2) tick(); reset = 1'b1;
      model_clear();
      checks++; if (dut_board !== 18'd0) $display("FAIL reset_board got %h want 0", dut_board); else passed++;
      checks++; if (turn !== 2'b01) $display("FAIL reset_turn got %b want 01", turn); else passed++;
      checks++; if (move_count !== 4'd0) $display("FAIL reset_count got %0d want 0", move_count); else passed++;
      checks++; if ({game_over, result} !== 3'b000) $display("FAIL reset_done got %b want 000", {game_over, result}); else passed++;
      checks++; if ({mv_if.move_ready, mv_if.move_ack, mv_if.move_err} !== 3'b100)
         $display("FAIL reset_hs got %b want 100", {mv_if.move_ready, mv_if.move_ack, mv_if.move_err}); else passed++;
   endtask

   task automatic test_first_move();
      bit ack, err, exp;
      exp = model_move(5);
      send_move(5, ack, err);
      checks++; if ({ack, err} !== {exp, !exp}) $display("FAIL first_ackerr got %b%b want %b%b", ack, err, exp, !exp); else passed++;
      checks++; if (dut_board !== model_board()) $display("FAIL first_board got %h want %h", dut_board, model_board()); else passed++;
      checks++; if ({turn, move_count} !== {mturn, 4'(mcount)}) $display("FAIL first_turncnt got %b/%0d want %b/%0d", turn, move_count, mturn, mcount); else passed++;
      checks++; if (mv_if.move_ready !== 1'b0) $display("FAIL first_ready0 got %b want 0", mv_if.move_ready); else passed++;
      tick();
      checks++; if ({mv_if.move_ready, mv_if.move_ack} !== 2'b00) $display("FAIL first_ready1 got %b want 00", {mv_if.move_ready, mv_if.move_ack}); else passed++;
      tick();
      checks++; if (mv_if.move_ready !== 1'b1) $display("FAIL first_ready2 got %b want 1", mv_if.move_ready); else passed++;
   endtask

   task automatic test_illegal();
      int bad [4] = '{5, 0, 10, 15};
      bit ack, err;
      foreach (bad[k]) begin
         send_move(bad[k], ack, err);
         checks++; if ({ack, err} !== 2'b01) $display("FAIL illegal_%0d got ack%b err%b want ack0 err1", bad[k], ack, err); else passed++;
         tick();
         checks++; if (mv_if.move_err !== 1'b0) $display("FAIL illegal_pulse_%0d err still %b want 0", bad[k], mv_if.move_err); else passed++;
      end
      checks++; if ({dut_board, turn, move_count} !== {model_board(), mturn, 4'(mcount)})
         $display("FAIL illegal_state got %h/%b/%0d want %h/%b/%0d", dut_board, turn, move_count, model_board(), mturn, mcount); else passed++;
   endtask

   task automatic play_seq(input int seq [], input string tag);
      bit ack, err, exp;
      foreach (seq[k]) begin
         exp = model_move(seq[k]);
         send_move(seq[k], ack, err);
         checks++; if ({ack, err} !== {exp, !exp}) $display("FAIL %s_move%0d got %b%b want %b%b", tag, k, ack, err, exp, !exp); else passed++;
         if (ack) settle();
      end
   endtask

   task automatic test_p1_wins();
      int seq [] = '{1, 4, 2, 7, 3};
      bit ack, err;
      start_game();
      play_seq(seq, "win");
      checks++; if ({game_over, result} !== 3'b101) $display("FAIL win_result got %b/%b want 1/01", game_over, result); else passed++;
      repeat (2) begin
         send_move(6, ack, err);
         checks++; if ({ack, err} !== 2'b01) $display("FAIL done_err got ack%b err%b want ack0 err1", ack, err); else passed++;
      end
      checks++; if (dut_board !== model_board()) $display("FAIL done_frozen got %h want %h", dut_board, model_board()); else passed++;
   endtask

   task automatic test_tie(input bit stub);
      int seq [] = '{1, 2, 3, 5, 4, 6, 8, 7, 9};
      force_zero = stub;
      start_game();
      play_seq(seq, stub ? "tie_stub" : "tie");
      checks++; if ({move_count, game_over, result} !== {4'd9, 1'b1, 2'b11})
         $display("FAIL tie%0d got cnt%0d over%b res%b want cnt9 over1 res11", stub, move_count, game_over, result); else passed++;
      force_zero = 1'b0;
   endtask

   task automatic check_cleared(input string tag);
      checks++; if ({dut_board, turn, move_count, result, game_over} !== {18'd0, 2'b01, 4'd0, 2'b00, 1'b0})
         $display("FAIL %s_clear got %h/%b/%0d/%b/%b want 0/01/0/00/0", tag, dut_board, turn, move_count, result, game_over); else passed++;
      checks++; if ({mv_if.move_ready, mv_if.move_ack, mv_if.move_err} !== 3'b100)
         $display("FAIL %s_hs got %b want 100", tag, {mv_if.move_ready, mv_if.move_ack, mv_if.move_err}); else passed++;
   endtask

   task automatic test_new_game_collide();
      bit ack, err;
      int seq [] = '{1, 4, 2, 7, 3};
      start_game();
      send_move(5, ack, err);
      tick();
      new_game = 1'b1; mv_if.move_valid = 1'b1; mv_if.move_pos = 4'd1;
      tick();
      new_game = 1'b0; mv_if.move_valid = 1'b0;
      model_clear();
      check_cleared("ng_settle");
      play_seq(seq, "ng_pre");
      new_game = 1'b1; mv_if.move_valid = 1'b1; mv_if.move_pos = 4'd6;
      tick();
      new_game = 1'b0; mv_if.move_valid = 1'b0;
      model_clear();
      check_cleared("ng_done");
   endtask

   task automatic test_reset_mid_settle();
      bit ack, err;
      start_game();
      send_move(3, ack, err);
      reset = 1'b0; tick(); reset = 1'b1;
      model_clear();
      check_cleared("rst_settle");
      void'(model_move(9));
      send_move(9, ack, err);
      checks++; if ({ack, dut_board, move_count} !== {1'b1, model_board(), 4'd1})
         $display("FAIL rst_next got ack%b %h cnt%0d want ack1 %h cnt1", ack, dut_board, move_count, model_board()); else passed++;
      settle();
   endtask

   task automatic test_random();
      bit ack, err, exp;
      int p;
      start_game();
      for (int n = 0; n < 60; n++) begin
         if (mover && $urandom_range(0, 2) == 0) start_game();
         p = $urandom_range(0, 11);
         exp = model_move(p);
         send_move(p, ack, err);
         checks++; if ({ack, err} !== {exp, !exp}) $display("FAIL rnd%0d_ackerr pos%0d got %b%b want %b%b", n, p, ack, err, exp, !exp); else passed++;
         if (ack) settle();
         checks++; if ({dut_board, turn, move_count} !== {model_board(), mturn, 4'(mcount)})
            $display("FAIL rnd%0d_state got %h/%b/%0d want %h/%b/%0d", n, dut_board, turn, move_count, model_board(), mturn, mcount); else passed++;
         checks++; if ({game_over, result, mv_if.move_ready} !== {mover, mres, !mover})
            $display("FAIL rnd%0d_end got %b/%b/%b want %b/%b/%b", n, game_over, result, mv_if.move_ready, mover, mres, !mover); else passed++;
      end
   endtask

   initial begin
      reset = 1'b0; new_game = 1'b0; force_zero = 1'b0;
      mv_if.move_valid = 1'b0; mv_if.move_pos = 4'd0;
      test_reset();
      test_first_move();
      test_illegal();
      test_p1_wins();
      test_tie(1'b0);
      test_tie(1'b1);
      test_new_game_collide();
      test_reset_mid_settle();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
